// File: rtl/interrupt_sequencer_if.sv
// Memory bus between the interrupt sequencer and the 6502 bus/memory side.
// Latency: combinational wires only; the sequencer decodes addr/we/data_out from its state register.
// Backpressure: rdy low stalls read cycles; write cycles always complete.
//
// Signals:
//   addr     bus address driven by the sequencer
//   data_out bus write data driven by the sequencer
//   we       write strobe driven by the sequencer
//   data_in  memory read data returned to the sequencer
//   rdy      6502 RDY; low stalls read cycles only
interface interrupt_sequencer_if;
    logic [15:0] addr;
    logic [7:0]  data_out;
    logic        we;
    logic [7:0]  data_in;
    logic        rdy;

    modport master (
        output addr,
        output data_out,
        output we,
        input  data_in,
        input  rdy
    );

    modport slave (
        input  addr,
        input  data_out,
        input  we,
        output data_in,
        output rdy
    );
endinterface

// File: rtl/interrupt_sequencer.sv
// NMOS 6502 RST/NMI/IRQ/BRK entry sequencer: two dummy reads, three pushes, vector fetch, PC/SP hand-off.
// Latency: start registered off instr_done (or pending reset); pc_load 8 cycles after the start edge when rdy=1.
// Backpressure: rdy low stalls dummy reads, vector reads and RST stack reads; real pushes never stall.
//
// Ports:
//   clk, reset_n     CPU clock, asynchronous active-low reset
//   bus              memory bus (addr, data_out, we out; data_in, rdy in)
//   irq_pending      IRQ level request, masked by i_flag
//   nmi_pending      latched NMI request; cleared upstream by nmi_ack
//   i_flag           P.I
//   brk_req          BRK decoded, qualified by instr_done
//   instr_done       last cycle of current instruction
//   pc_in/p_in/sp_in core PC (PC+2 for BRK), status and stack pointer
//   busy             sequence in progress; core holds fetch
//   set_i            one-cycle pulse to set P.I
//   nmi_ack          one-cycle pulse when the NMI vector is taken
//   pc_load          one-cycle pulse; pc_out and sp_out valid
//   pc_out, sp_out   vector target and final stack pointer
module interrupt_sequencer (
    input  logic                         clk,
    input  logic                         reset_n,
    interrupt_sequencer_if.master        bus,
    input  logic                         irq_pending,
    input  logic                         nmi_pending,
    input  logic                         i_flag,
    input  logic                         brk_req,
    input  logic                         instr_done,
    input  logic [15:0]                  pc_in,
    input  logic [7:0]                   p_in,
    input  logic [7:0]                   sp_in,
    output logic                         busy,
    output logic                         set_i,
    output logic                         nmi_ack,
    output logic                         pc_load,
    output logic [15:0]                  pc_out,
    output logic [7:0]                   sp_out
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_DUM1   = 4'd1,
        S_DUM2   = 4'd2,
        S_PUSH_H = 4'd3,
        S_PUSH_L = 4'd4,
        S_PUSH_P = 4'd5,
        S_VEC_LO = 4'd6,
        S_VEC_HI = 4'd7,
        S_LOAD   = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        SRC_RST = 2'd0,
        SRC_NMI = 2'd1,
        SRC_IRQ = 2'd2,
        SRC_BRK = 2'd3
    } src_t;

    localparam logic [15:0] VEC_NMI = 16'hFFFA;
    localparam logic [15:0] VEC_RST = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ = 16'hFFFE;

    state_t      state;
    src_t        src;
    logic [7:0]  sp_w;
    logic [7:0]  vec_lo;
    logic        rst_pend;
    logic [15:0] base;

    // ------------------------------------------------------------------
    // Start decision (evaluated only in IDLE)
    // ------------------------------------------------------------------
    logic irq_ok;
    logic start;
    src_t start_src;

    always_comb begin
        irq_ok    = irq_pending & ~i_flag;
        start     = rst_pend | (instr_done & (nmi_pending | irq_ok | brk_req));
        start_src = SRC_BRK;
        if (rst_pend)
            start_src = SRC_RST;
        else if (nmi_pending)
            start_src = SRC_NMI;
        else if (irq_ok)
            start_src = SRC_IRQ;
    end

    // ------------------------------------------------------------------
    // Stall: only read cycles honour rdy. During RST the push states are
    // dummy stack reads, so they stall too.
    // ------------------------------------------------------------------
    logic read_cycle;
    logic stall;

    always_comb begin
        case (state)
            S_DUM1, S_DUM2, S_VEC_LO, S_VEC_HI: read_cycle = 1'b1;
            S_PUSH_H, S_PUSH_L, S_PUSH_P:       read_cycle = (src == SRC_RST);
            default:                            read_cycle = 1'b0;
        endcase
        stall = read_cycle & ~bus.rdy;
    end

    // ------------------------------------------------------------------
    // Sequencer state and registered pulse outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            src      <= SRC_RST;
            sp_w     <= 8'h00;
            vec_lo   <= 8'h00;
            rst_pend <= 1'b1;
            base     <= VEC_IRQ;
            set_i    <= 1'b0;
            nmi_ack  <= 1'b0;
            pc_load  <= 1'b0;
            pc_out   <= 16'h0000;
            sp_out   <= 8'h00;
        end else begin
            set_i   <= 1'b0;
            nmi_ack <= 1'b0;
            pc_load <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        src   <= start_src;
                        state <= S_DUM1;
                        if (rst_pend) begin
                            // Reset entry walks the stack from 00 down to FD.
                            sp_w     <= 8'h00;
                            rst_pend <= 1'b0;
                        end else begin
                            sp_w <= sp_in;
                        end
                    end
                end

                S_DUM1: if (!stall) state <= S_DUM2;

                S_DUM2: if (!stall) state <= S_PUSH_H;

                S_PUSH_H: begin
                    if (!stall) begin
                        sp_w  <= sp_w - 8'd1;
                        state <= S_PUSH_L;
                    end
                end

                S_PUSH_L: begin
                    if (!stall) begin
                        sp_w  <= sp_w - 8'd1;
                        state <= S_PUSH_P;
                    end
                end

                S_PUSH_P: begin
                    if (!stall) begin
                        sp_w  <= sp_w - 8'd1;
                        state <= S_VEC_LO;
                        set_i <= 1'b1;
                        // Vector is chosen here, not at start: a pending NMI
                        // hijacks an IRQ/BRK already in progress (NMOS behaviour).
                        if (src == SRC_RST) begin
                            base <= VEC_RST;
                        end else if (nmi_pending) begin
                            base    <= VEC_NMI;
                            nmi_ack <= 1'b1;
                        end else begin
                            base <= VEC_IRQ;
                        end
                    end
                end

                S_VEC_LO: begin
                    if (!stall) begin
                        vec_lo <= bus.data_in;
                        state  <= S_VEC_HI;
                    end
                end

                S_VEC_HI: begin
                    if (!stall) begin
                        pc_out  <= {bus.data_in, vec_lo};
                        sp_out  <= sp_w;
                        pc_load <= 1'b1;
                        state   <= S_LOAD;
                    end
                end

                S_LOAD: state <= S_IDLE;

                default: state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Moore bus decode. Reset forces state to IDLE asynchronously, so we
    // drops immediately without extra gating.
    // ------------------------------------------------------------------
    logic [7:0]  p_push;
    logic [15:0] addr_c;
    logic [7:0]  data_c;
    logic        we_c;

    always_comb begin
        // Bit 5 always reads 1 on the stack; B is 1 only for BRK.
        p_push    = (p_in | 8'h20) & 8'hEF;
        p_push[4] = (src == SRC_BRK);

        addr_c = pc_in;
        data_c = 8'h00;
        we_c   = 1'b0;

        case (state)
            S_PUSH_H: begin
                addr_c = {8'h01, sp_w};
                data_c = pc_in[15:8];
                we_c   = (src != SRC_RST);
            end
            S_PUSH_L: begin
                addr_c = {8'h01, sp_w};
                data_c = pc_in[7:0];
                we_c   = (src != SRC_RST);
            end
            S_PUSH_P: begin
                addr_c = {8'h01, sp_w};
                data_c = p_push;
                we_c   = (src != SRC_RST);
            end
            S_VEC_LO: addr_c = base;
            S_VEC_HI: addr_c = base + 16'd1;
            default: begin
                addr_c = pc_in;
            end
        endcase
    end

    assign bus.addr     = addr_c;
    assign bus.data_out = data_c;
    assign bus.we       = we_c;
    assign busy         = (state != S_IDLE);

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: per-cycle vector table plus a hand-written reset-abort sequence.
module tb_interrupt_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        irq_pending, nmi_pending, i_flag, brk_req, instr_done;
    logic [15:0] pc_in;
    logic [7:0]  p_in, sp_in;
    logic        busy, set_i, nmi_ack, pc_load;
    logic [15:0] pc_out;
    logic [7:0]  sp_out;

    always #5 clk = ~clk;

    interrupt_sequencer_if bus_if ();

    interrupt_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus_if),
        .irq_pending (irq_pending),
        .nmi_pending (nmi_pending),
        .i_flag      (i_flag),
        .brk_req     (brk_req),
        .instr_done  (instr_done),
        .pc_in       (pc_in),
        .p_in        (p_in),
        .sp_in       (sp_in),
        .busy        (busy),
        .set_i       (set_i),
        .nmi_ack     (nmi_ack),
        .pc_load     (pc_load),
        .pc_out      (pc_out),
        .sp_out      (sp_out)
    );

    typedef struct {
        logic        rdy, done, irq, nmi, brk, iflag;
        logic [7:0]  din;
        logic [15:0] pc;
        logic [7:0]  p, sp;
        logic [15:0] e_addr;
        logic [7:0]  e_dout;
        logic        e_we, e_busy, e_seti, e_ack, e_load;
        logic [15:0] e_pc;
        logic [7:0]  e_sp;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] c_pc;
    logic [7:0]  c_p, c_sp;
    logic        c_iflag;
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic ctx(input logic [15:0] pc, input logic [7:0] p, input logic [7:0] sp, input logic ifl);
        c_pc = pc; c_p = p; c_sp = sp; c_iflag = ifl;
    endtask

    task automatic row(input logic rdy, input logic done, input logic irq, input logic nmi,
                       input logic brk, input logic [7:0] din, input logic [15:0] ea,
                       input logic [7:0] ed, input logic ewe, input logic ebusy, input logic eseti,
                       input logic eack, input logic eload, input logic [15:0] epc, input logic [7:0] esp);
        vec_t v;
        v.rdy = rdy; v.done = done; v.irq = irq; v.nmi = nmi; v.brk = brk; v.iflag = c_iflag;
        v.din = din; v.pc = c_pc; v.p = c_p; v.sp = c_sp;
        v.e_addr = ea; v.e_dout = ed; v.e_we = ewe; v.e_busy = ebusy;
        v.e_seti = eseti; v.e_ack = eack; v.e_load = eload; v.e_pc = epc; v.e_sp = esp;
        tbl.push_back(v);
    endtask

    // IDLE cycle: nothing on the bus, no pulses.
    task automatic idle(input logic done, input logic irq, input logic nmi, input logic brk);
        row(1'b1, done, irq, nmi, brk, 8'h00, 16'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h00);
    endtask

    // Read cycle (dummy, RST stack read or vector read).
    task automatic rd(input logic rdy, input logic nmi, input logic [7:0] din, input logic [15:0] a,
                      input logic seti, input logic ack);
        row(rdy, 1'b0, 1'b0, nmi, 1'b0, din, a, 8'h00, 1'b0, 1'b1, seti, ack, 1'b0, 16'h0, 8'h00);
    endtask

    // Stack write cycle.
    task automatic wr(input logic rdy, input logic nmi, input logic [15:0] a, input logic [7:0] d);
        row(rdy, 1'b0, 1'b0, nmi, 1'b0, 8'h00, a, d, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h00);
    endtask

    // LOAD cycle.
    task automatic ld(input logic [15:0] pc, input logic [7:0] sp);
        row(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, pc, sp);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    initial begin
        logic ok;
        logic got_load;

        reset_n = 1'b0;
        irq_pending = 1'b0; nmi_pending = 1'b0; i_flag = 1'b1; brk_req = 1'b0; instr_done = 1'b0;
        pc_in = 16'h0000; p_in = 8'h00; sp_in = 8'h00;
        bus_if.rdy = 1'b1; bus_if.data_in = 8'h00;

        // Post-reset sequence: stack reads 0100/01FF/01FE, vector FFFC/FFFD = 8000.
        ctx(16'hC000, 8'h00, 8'h55, 1'b1);
        idle(0, 0, 0, 0);
        rd(1, 0, 8'h00, 16'hC000, 0, 0);
        rd(1, 0, 8'h00, 16'hC000, 0, 0);
        rd(1, 0, 8'h00, 16'h0100, 0, 0);
        rd(1, 0, 8'h00, 16'h01FF, 0, 0);
        rd(1, 0, 8'h00, 16'h01FE, 0, 0);
        rd(1, 0, 8'h00, 16'hFFFC, 1, 0);
        rd(1, 0, 8'h80, 16'hFFFD, 0, 0);
        ld(16'h8000, 8'hFD);
        idle(0, 0, 0, 0);

        // IRQ, I=0; IRQ drops after start and must not abort.
        ctx(16'h1234, 8'h00, 8'hFF, 1'b0);
        idle(1, 1, 0, 0);
        rd(1, 0, 8'h00, 16'h1234, 0, 0);
        rd(1, 0, 8'h00, 16'h1234, 0, 0);
        wr(1, 0, 16'h01FF, 8'h12);
        wr(1, 0, 16'h01FE, 8'h34);
        wr(1, 0, 16'h01FD, 8'h20);
        rd(1, 0, 8'h00, 16'hFFFE, 1, 0);
        rd(1, 0, 8'h90, 16'hFFFF, 0, 0);
        ld(16'h9000, 8'hFC);

        // IRQ masked by I=1.
        ctx(16'h1234, 8'h00, 8'hFF, 1'b1);
        idle(1, 1, 0, 0);
        idle(0, 1, 0, 0);

        // IRQ that drops before the boundary is ignored.
        ctx(16'h1234, 8'h00, 8'hFF, 1'b0);
        idle(0, 1, 0, 0);
        idle(1, 0, 0, 0);
        idle(0, 0, 0, 0);

        // BRK, P=01 -> pushed 31, vector FFFE.
        ctx(16'h2002, 8'h01, 8'h80, 1'b0);
        idle(1, 0, 0, 1);
        rd(1, 0, 8'h00, 16'h2002, 0, 0);
        rd(1, 0, 8'h00, 16'h2002, 0, 0);
        wr(1, 0, 16'h0180, 8'h20);
        wr(1, 0, 16'h017F, 8'h02);
        wr(1, 0, 16'h017E, 8'h31);
        rd(1, 0, 8'h34, 16'hFFFE, 1, 0);
        rd(1, 0, 8'h12, 16'hFFFF, 0, 0);
        ld(16'h1234, 8'h7D);

        // NMI raised during PUSH_L of an IRQ: hijacks to FFFA, B stays 0.
        ctx(16'h4567, 8'hC3, 8'h40, 1'b0);
        idle(1, 1, 0, 0);
        rd(1, 0, 8'h00, 16'h4567, 0, 0);
        rd(1, 0, 8'h00, 16'h4567, 0, 0);
        wr(1, 0, 16'h0140, 8'h45);
        wr(1, 1, 16'h013F, 8'h67);
        wr(1, 1, 16'h013E, 8'hE3);
        rd(1, 1, 8'h00, 16'hFFFA, 1, 1);
        rd(1, 0, 8'hA0, 16'hFFFB, 0, 0);
        ld(16'hA000, 8'h3D);
        idle(0, 0, 0, 0);

        // rdy=0 for 3 cycles in VEC_LO: LOAD slips by exactly 3.
        ctx(16'h1000, 8'h00, 8'hFF, 1'b0);
        idle(1, 1, 0, 0);
        rd(1, 0, 8'h00, 16'h1000, 0, 0);
        rd(1, 0, 8'h00, 16'h1000, 0, 0);
        wr(1, 0, 16'h01FF, 8'h10);
        wr(1, 0, 16'h01FE, 8'h00);
        wr(1, 0, 16'h01FD, 8'h20);
        rd(0, 0, 8'h00, 16'hFFFE, 1, 0);
        rd(0, 0, 8'h00, 16'hFFFE, 0, 0);
        rd(0, 0, 8'h00, 16'hFFFE, 0, 0);
        rd(1, 0, 8'h00, 16'hFFFE, 0, 0);
        rd(1, 0, 8'h90, 16'hFFFF, 0, 0);
        ld(16'h9000, 8'hFC);

        // rdy=0 during real pushes: pushes advance, stall lands on VEC_LO.
        ctx(16'hABCD, 8'h00, 8'h10, 1'b0);
        idle(1, 1, 0, 0);
        rd(1, 0, 8'h00, 16'hABCD, 0, 0);
        rd(1, 0, 8'h00, 16'hABCD, 0, 0);
        wr(0, 0, 16'h0110, 8'hAB);
        wr(0, 0, 16'h010F, 8'hCD);
        wr(0, 0, 16'h010E, 8'h20);
        rd(0, 0, 8'h00, 16'hFFFE, 1, 0);
        rd(1, 0, 8'h11, 16'hFFFE, 0, 0);
        rd(1, 0, 8'h22, 16'hFFFF, 0, 0);
        ld(16'h2211, 8'h0D);
        idle(0, 0, 0, 0);

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        chk("reset_outputs", {busy, bus_if.we, set_i, nmi_ack, pc_load}, 5'b0);

        @(posedge clk);
        #2 reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            bus_if.rdy = tbl[i].rdy; instr_done = tbl[i].done; irq_pending = tbl[i].irq;
            nmi_pending = tbl[i].nmi; brk_req = tbl[i].brk; i_flag = tbl[i].iflag;
            bus_if.data_in = tbl[i].din; pc_in = tbl[i].pc; p_in = tbl[i].p; sp_in = tbl[i].sp;
            #1;
            ok = (busy === tbl[i].e_busy) && (bus_if.we === tbl[i].e_we) && (set_i === tbl[i].e_seti)
                 && (nmi_ack === tbl[i].e_ack) && (pc_load === tbl[i].e_load);
            if (tbl[i].e_busy && !tbl[i].e_load && (bus_if.addr !== tbl[i].e_addr)) ok = 1'b0;
            if (tbl[i].e_we && (bus_if.data_out !== tbl[i].e_dout)) ok = 1'b0;
            if (tbl[i].e_load && ((pc_out !== tbl[i].e_pc) || (sp_out !== tbl[i].e_sp))) ok = 1'b0;
            n_vec++;
            if (!ok) begin
                n_bad++;
                $display("FAIL vec %0d: got addr=%h dout=%h we=%b busy=%b set_i=%b ack=%b load=%b pc=%h sp=%h; want addr=%h dout=%h we=%b busy=%b set_i=%b ack=%b load=%b pc=%h sp=%h",
                         i, bus_if.addr, bus_if.data_out, bus_if.we, busy, set_i, nmi_ack, pc_load, pc_out, sp_out,
                         tbl[i].e_addr, tbl[i].e_dout, tbl[i].e_we, tbl[i].e_busy, tbl[i].e_seti,
                         tbl[i].e_ack, tbl[i].e_load, tbl[i].e_pc, tbl[i].e_sp);
            end
        end

        // Reset mid-sequence: we drops asynchronously, RST sequence follows release.
        @(negedge clk);
        bus_if.rdy = 1'b1; instr_done = 1'b1; irq_pending = 1'b1; nmi_pending = 1'b0; brk_req = 1'b0;
        i_flag = 1'b0; pc_in = 16'h5555; p_in = 8'h00; sp_in = 8'hFF;
        @(negedge clk);
        instr_done = 1'b0; irq_pending = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("abort_push_we", {bus_if.we, bus_if.addr}, {1'b1, 16'h01FF});
        reset_n = 1'b0;
        #1;
        chk("abort_async_idle", {bus_if.we, busy}, 2'b00);
        @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_idle_after_release", busy, 1'b0);
        @(negedge clk);
        #1;
        chk("rst_dum1_addr", {busy, bus_if.addr}, {1'b1, 16'h5555});
        repeat (2) @(negedge clk);
        bus_if.rdy = 1'b0;
        #1;
        chk("rst_push_h_read", {bus_if.we, bus_if.addr}, {1'b0, 16'h0100});
        @(negedge clk);
        #1;
        chk("rst_push_h_stall1", bus_if.addr, 16'h0100);
        @(negedge clk);
        bus_if.rdy = 1'b1;
        #1;
        chk("rst_push_h_stall2", bus_if.addr, 16'h0100);
        @(negedge clk);
        #1;
        chk("rst_push_l_after_stall", bus_if.addr, 16'h01FF);

        got_load = 1'b0;
        for (int k = 0; k < 20 && !got_load; k++) begin
            @(negedge clk);
            #1;
            if (pc_load === 1'b1) got_load = 1'b1;
            bus_if.data_in = (bus_if.addr == 16'hFFFC) ? 8'h34 :
                             (bus_if.addr == 16'hFFFD) ? 8'h12 : 8'h00;
        end
        chk("rst_pc_load_seen", got_load, 1'b1);
        chk("rst_pc_sp", {pc_out, sp_out}, {16'h1234, 8'hFD});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/interrupt_sequencer.md
# interrupt_sequencer

Drives the 7-cycle NMOS 6502 interrupt/reset entry sequence. Sits directly downstream of the timing/interrupt unit: consumes its `irq_pending` and `nmi_pending` flags at instruction boundaries. Sequences the stack pushes of PCH, PCL and P, then fetches the vector, and hands the new PC and SP to the core. Also services BRK and the post-reset sequence.

## Interface
- No parameters.
- `clk`  in  1  CPU clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rdy`  in  1  6502 RDY; low stalls read cycles only.
- `irq_pending`  in  1  IRQ level request from the timing unit.
- `nmi_pending`  in  1  latched NMI request from the timing unit.
- `i_flag`  in  1  P.I; masks IRQ.
- `brk_req`  in  1  BRK opcode decoded; valid with `instr_done`.
- `instr_done`  in  1  last cycle of the current instruction; the start point.
- `pc_in`  in  16  PC to push (for BRK, the core supplies PC+2).
- `p_in`  in  8  status register to push.
- `sp_in`  in  8  stack pointer at sequence start.
- `data_in`  in  8  memory read data.
- `addr`  out  16  bus address.
- `data_out`  out  8  bus write data.
- `we`  out  1  write strobe.
- `busy`  out  1  sequence active; the core must hold fetch.
- `set_i`  out  1  1-cycle pulse: set P.I.
- `nmi_ack`  out  1  1-cycle pulse: clear `nmi_pending` upstream.
- `pc_load`  out  1  1-cycle pulse: load `pc_out`.
- `pc_out`  out  16  vector read from memory.
- `sp_out`  out  8  final SP; valid with `pc_load`.

## Operation
- States: IDLE, DUM1, DUM2, PUSH_H, PUSH_L, PUSH_P, VEC_LO, VEC_HI, LOAD.
- Internal registers: `src` (RST/NMI/IRQ/BRK), `sp_w[7:0]`, `vec_lo[7:0]`, `rst_pend`.
- Reset sets `rst_pend=1`, state=IDLE, `sp_w=00`, and all pulse outputs to 0.
- In IDLE, a sequence starts when `rst_pend` is set, or when `instr_done` is high and a source is present.
- Start priority: RST, then NMI, then IRQ (only when `i_flag=0`), then BRK.
- On start: latch `src` and `sp_w<=sp_in` (`sp_w<=00` for RST). RST also clears `rst_pend`.
- Bus outputs are decoded from the state register (Moore):
  - DUM1, DUM2: `addr=pc_in`, `we=0`.
  - PUSH_H / PUSH_L / PUSH_P: `addr={8'h01,sp_w}`, `data_out` = `pc_in[15:8]` / `pc_in[7:0]` / P-value.
  - `we=1`, except `we=0` for RST (dummy stack reads).
  - `sp_w` decrements (mod 256) on leaving each push state.
  - P-value = `p_in | 8'h20`; bit4 (B) =1 for BRK, =0 for IRQ/NMI.
  - VEC_LO: `addr=base`; `vec_lo<=data_in` on the exit edge.
  - VEC_HI: `addr=base+1`.
- `base` is resolved at VEC_LO entry:
  - RST → FFFC.
  - `nmi_pending` high (any non-RST source; NMOS hijack) → FFFA.
  - IRQ/BRK → FFFE.
- `set_i` and `nmi_ack` pulse during VEC_LO. `nmi_ack` pulses only when base=FFFA.
- LOAD: `pc_load=1`, `pc_out={data_in_latched_hi,vec_lo}`, `sp_out=sp_w`. Next state is IDLE.
- `busy=1` in every state except IDLE.
- An IRQ that drops before start is ignored. An IRQ that drops mid-sequence does not abort the sequence.
- NMI arriving after VEC_LO entry is not taken now; it is serviced at the next boundary.

## Timing
- Start is registered: `instr_done` at edge N gives DUM1 during cycle N+1.
- With `rdy=1`, a sequence is 8 cycles: 7 bus cycles (DUM1 through VEC_HI) plus LOAD.
- `pc_load` occurs exactly 8 cycles after the start edge.
- `rdy=0` holds state, `sp_w` and `vec_lo` in DUM1, DUM2, VEC_LO, VEC_HI and all RST push states.
- Write push states advance regardless of `rdy`.
- Reset mid-sequence: immediate return to IDLE and `rst_pend=1`. `we` goes 0 asynchronously; the RST sequence starts on the first edge after release.
- After the RST sequence completes, `sp_out` = FD.

## Test plan
- Reset release, `rdy=1`:
  - Stack reads at 0100, 01FF, 01FE with `we=0`.
  - Reads at FFFC=00 and FFFD=80 → `pc_load` with `pc_out=8000`, `sp_out=FD`, `set_i` pulse, no `nmi_ack`.
- IRQ with `i_flag=0`, `pc_in=1234`, `p_in=00`, `sp_in=FF`:
  - Writes 01FF←12, 01FE←34, 01FD←20.
  - Vector FFFE/FFFF=00/90 → `pc_out=9000`, `sp_out=FC`.
- IRQ with `i_flag=1`, `instr_done` pulsed → stays in IDLE, `busy=0`.
- BRK with `p_in=01` → P push = 31, vector FFFE.
- NMI asserted during PUSH_L of an IRQ sequence:
  - Vector reads at FFFA/FFFB; `nmi_ack` pulses in VEC_LO.
  - Pushed P B-bit = 0.
- `rdy=0` for 3 cycles during VEC_LO:
  - `addr` holds FFFE; `pc_load` is delayed exactly 3 cycles.
- `rdy=0` during the PUSH states of a non-RST sequence:
  - Push cycles still advance; the stall then happens at VEC_LO.
